// File: rtl/ted_multimode_if.sv
// Sample/strobe input bus and timing-error output bus of the symbol timing error detector.
interface ted_multimode_if #(
    parameter int DATA_WIDTH = 16,
    parameter int OUT_WIDTH  = 16
);
    logic                          valid_in;
    logic                          strobe_in;
    logic [1:0]                    mode;
    logic signed [DATA_WIDTH-1:0]  I_in;
    logic signed [DATA_WIDTH-1:0]  Q_in;
    logic signed [OUT_WIDTH-1:0]   e_k;
    logic                          ted_valid;
    logic                          sat_flag;

    modport master (
        output valid_in, strobe_in, mode, I_in, Q_in,
        input  e_k, ted_valid, sat_flag
    );

    modport slave (
        input  valid_in, strobe_in, mode, I_in, Q_in,
        output e_k, ted_valid, sat_flag
    );
endinterface

// File: rtl/ted_multimode.sv
// Symbol timing error detector: zero-crossing or Gardner, real or complex input,
// 2 samples/symbol, registered and saturated error with a one-cycle valid pulse.
module ted_multimode #(
    parameter int DATA_WIDTH = 16,
    parameter int OUT_WIDTH  = 16,
    parameter int GSHIFT     = 15
) (
    input logic            clk,
    input logic            rst,
    ted_multimode_if.slave bus
);
    // Common working width: wide enough for the complex Gardner sum, which dominates.
    localparam int WW = 2 * DATA_WIDTH + 2;

    function automatic logic signed [WW-1:0] sext_f(input logic signed [DATA_WIDTH-1:0] x);
        return {{(WW - DATA_WIDTH){x[DATA_WIDTH-1]}}, x};
    endfunction

    function automatic logic signed [WW-1:0] sgn_f(input logic signed [DATA_WIDTH-1:0] x);
        logic signed [WW-1:0] r;
        if (x == {DATA_WIDTH{1'b0}}) begin
            r = {WW{1'b0}};
        end else if (x[DATA_WIDTH-1]) begin
            r = {WW{1'b1}};
        end else begin
            r = {{(WW - 1){1'b0}}, 1'b1};
        end
        return r;
    endfunction

    // Returns {clipped, value}.
    function automatic logic [OUT_WIDTH:0] sat_f(input logic signed [WW-1:0] x);
        logic signed [WW-1:0] max_v;
        logic signed [WW-1:0] min_v;
        logic [OUT_WIDTH:0]   r;
        max_v = {{(WW - OUT_WIDTH + 1){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
        min_v = {{(WW - OUT_WIDTH + 1){1'b1}}, {(OUT_WIDTH - 1){1'b0}}};
        if (x > max_v) begin
            r = {1'b1, 1'b0, {(OUT_WIDTH - 1){1'b1}}};
        end else if (x < min_v) begin
            r = {1'b1, 1'b1, {(OUT_WIDTH - 1){1'b0}}};
        end else begin
            r = {1'b0, x[OUT_WIDTH-1:0]};
        end
        return r;
    endfunction

    logic signed [DATA_WIDTH-1:0] i_d1_r, i_d2_r, q_d1_r, q_d2_r;
    logic [1:0]                   fill_r;
    logic [1:0]                   mode_r;
    logic signed [OUT_WIDTH-1:0]  e_k_r;
    logic                         ted_valid_r;
    logic                         sat_r;

    logic                         mode_chg_s, emit_s, gardner_s, complex_s;
    logic signed [WW-1:0]         e_i_s, e_q_s, sum_s, raw_s;
    logic [OUT_WIDTH:0]           sat_s;

    // Error term for the current sample against the midpoint and previous symbol.
    always_comb begin
        gardner_s  = mode_r[1];
        complex_s  = mode_r[1] ^ mode_r[0];
        e_i_s      = {WW{1'b0}};
        e_q_s      = {WW{1'b0}};
        sum_s      = {WW{1'b0}};
        raw_s      = {WW{1'b0}};
        if (gardner_s) begin
            e_i_s = sext_f(i_d1_r) * (sext_f(i_d2_r) - sext_f(bus.I_in));
            e_q_s = sext_f(q_d1_r) * (sext_f(q_d2_r) - sext_f(bus.Q_in));
        end else begin
            e_i_s = sext_f(i_d1_r) * (sgn_f(bus.I_in) - sgn_f(i_d2_r));
            e_q_s = sext_f(q_d1_r) * (sgn_f(bus.Q_in) - sgn_f(q_d2_r));
        end
        if (complex_s) begin
            sum_s = e_i_s + e_q_s;
        end else begin
            sum_s = e_i_s;
        end
        if (gardner_s) begin
            raw_s = sum_s >>> GSHIFT;
        end else begin
            raw_s = sum_s;
        end
        sat_s      = sat_f(raw_s);
        mode_chg_s = (bus.mode != mode_r);
        emit_s     = bus.valid_in & bus.strobe_in & (fill_r == 2'd2) & ~mode_chg_s;
    end

    // History, fill tracking, mode flush and registered error output.
    always_ff @(posedge clk) begin
        if (rst) begin
            i_d1_r      <= {DATA_WIDTH{1'b0}};
            i_d2_r      <= {DATA_WIDTH{1'b0}};
            q_d1_r      <= {DATA_WIDTH{1'b0}};
            q_d2_r      <= {DATA_WIDTH{1'b0}};
            fill_r      <= 2'd0;
            mode_r      <= 2'b00;
            e_k_r       <= {OUT_WIDTH{1'b0}};
            ted_valid_r <= 1'b0;
            sat_r       <= 1'b0;
        end else begin
            ted_valid_r <= emit_s;
            sat_r       <= emit_s & sat_s[OUT_WIDTH];
            if (emit_s) begin
                e_k_r <= sat_s[OUT_WIDTH-1:0];
            end else begin
                e_k_r <= e_k_r;
            end
            if (bus.valid_in) begin
                i_d2_r <= i_d1_r;
                i_d1_r <= bus.I_in;
                q_d2_r <= q_d1_r;
                q_d1_r <= bus.Q_in;
            end else begin
                i_d2_r <= i_d2_r;
                i_d1_r <= i_d1_r;
                q_d2_r <= q_d2_r;
                q_d1_r <= q_d1_r;
            end
            // A mode change discards history; a sample arriving with it counts as the first.
            if (mode_chg_s) begin
                mode_r <= bus.mode;
                fill_r <= bus.valid_in ? 2'd1 : 2'd0;
            end else if (bus.valid_in && (fill_r != 2'd2)) begin
                mode_r <= mode_r;
                fill_r <= fill_r + 2'd1;
            end else begin
                mode_r <= mode_r;
                fill_r <= fill_r;
            end
        end
    end

    assign bus.e_k       = e_k_r;
    assign bus.ted_valid = ted_valid_r;
    assign bus.sat_flag  = sat_r;
endmodule

// File: tb/tb_ted_multimode.sv
// Directed bench: two instances (16-bit and 8-bit output, GSHIFT=8) fed identical samples.
module tb_ted_multimode;
    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    ted_multimode_if #(.DATA_WIDTH(16), .OUT_WIDTH(16)) if16 ();
    ted_multimode_if #(.DATA_WIDTH(16), .OUT_WIDTH(8))  if8 ();

    ted_multimode #(.DATA_WIDTH(16), .OUT_WIDTH(16), .GSHIFT(8)) dut16 (
        .clk (clk),
        .rst (rst),
        .bus (if16)
    );

    ted_multimode #(.DATA_WIDTH(16), .OUT_WIDTH(8), .GSHIFT(8)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (if8)
    );

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic s, input int i, input int q);
        if16.valid_in = v;  if8.valid_in = v;
        if16.strobe_in = s; if8.strobe_in = s;
        if16.I_in = 16'(i); if8.I_in = 16'(i);
        if16.Q_in = 16'(q); if8.Q_in = 16'(q);
    endtask

    task automatic set_mode(input logic [1:0] m);
        if16.mode = m;
        if8.mode  = m;
    endtask

    // One valid sample per cycle; outputs are looked at 1 time unit after the edge.
    task automatic apply(input logic s, input int i, input int q);
        @(negedge clk);
        drive(1'b1, s, i, q);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 0, 0);
    endtask

    task automatic idle(input logic s);
        @(negedge clk);
        drive(1'b0, s, 0, 0);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 0, 0);
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 1'b0, 0, 0);
        set_mode(2'b00);
        repeat (2) @(posedge clk);
        #1;
        check("rst_e16", if16.e_k, 0);
        check("rst_tv16", if16.ted_valid, 0);
        check("rst_sat16", if16.sat_flag, 0);
        check("rst_e8", if8.e_k, 0);
        check("rst_tv8", if8.ted_valid, 0);
        rst = 1'b0;

        // T1 zero-crossing real
        apply(1'b0, 100, 0);
        check("t1_tv_s1", if16.ted_valid, 0);
        apply(1'b0, 50, 0);
        apply(1'b1, -100, 0);
        check("t1_tv", if16.ted_valid, 1);
        check("t1_e16", if16.e_k, -100);
        check("t1_sat16", if16.sat_flag, 0);
        check("t1_e8", if8.e_k, -100);
        idle(1'b0);
        check("t1_tv_drop", if16.ted_valid, 0);
        check("t1_e16_hold", if16.e_k, -100);

        // T2 Gardner real (mode switch coincides with the first sample)
        set_mode(2'b11);
        apply(1'b0, 200, 0);
        apply(1'b0, 30, 0);
        apply(1'b1, -200, 0);
        check("t2_tv", if16.ted_valid, 1);
        check("t2_e16", if16.e_k, 46);
        check("t2_e8", if8.e_k, 46);

        // T3 zero-crossing complex
        set_mode(2'b01);
        apply(1'b0, 100, -80);
        apply(1'b0, 50, -40);
        apply(1'b1, -100, 80);
        check("t3_e16", if16.e_k, -180);
        check("t3_sat16", if16.sat_flag, 0);
        check("t3_e8_neg_clip", if8.e_k, -128);
        check("t3_sat8", if8.sat_flag, 1);

        // T4 positive saturation on the 8-bit output
        set_mode(2'b00);
        apply(1'b0, -5, 0);
        apply(1'b0, 1000, 0);
        apply(1'b1, 7, 0);
        check("t4_tv8", if8.ted_valid, 1);
        check("t4_e8", if8.e_k, 127);
        check("t4_sat8", if8.sat_flag, 1);
        check("t4_e16", if16.e_k, 2000);
        check("t4_sat16", if16.sat_flag, 0);

        // T5 mode switch mid-stream, strobes while refilling, floor of negative Gardner
        set_mode(2'b11);
        apply(1'b1, -200, 0);
        check("t5_tv_modechg", if16.ted_valid, 0);
        apply(1'b1, 30, 0);
        check("t5_tv_fill1", if16.ted_valid, 0);
        apply(1'b1, 200, 0);
        check("t5_tv_resume", if16.ted_valid, 1);
        check("t5_e16_floor", if16.e_k, -47);
        check("t5_e8_floor", if8.e_k, -47);
        idle(1'b1);
        check("t5_tv_strobe_novalid", if16.ted_valid, 0);
        apply(1'b1, 50, 0);
        check("t5_e16_nohist", if16.e_k, -16);
        apply(1'b0, 32767, 0);
        apply(1'b0, 32767, 0);
        apply(1'b1, -32768, 0);
        check("t5_e16_pos_clip", if16.e_k, 32767);
        check("t5_sat16", if16.sat_flag, 1);

        // T6 reset mid-stream with a valid strobed sample present
        @(negedge clk);
        rst = 1'b1;
        set_mode(2'b00);
        drive(1'b1, 1'b1, 500, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(1'b0, 1'b0, 0, 0);
        check("t6_e16", if16.e_k, 0);
        check("t6_tv16", if16.ted_valid, 0);
        check("t6_sat16", if16.sat_flag, 0);
        apply(1'b0, 100, 0);
        apply(1'b1, 50, 0);
        check("t6_tv_fill", if16.ted_valid, 0);
        apply(1'b1, -100, 0);
        check("t6_tv_resume", if16.ted_valid, 1);
        check("t6_e16", if16.e_k, -100);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
